cache_arbiter: RTL

Two-requester controller for the 2-entry `cache` block. It arbitrates round-robin between two clients and owns the cache's `read`/`write` strobes. It sequences the cache's multi-cycle write (hit-update or miss-allocate) to completion and returns a one-cycle response to the client that was granted. It sits between the client ports and the single `cache` instance. It is the only agent driving the cache inputs.

---
 rtl/cache_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Round-robin two-client front end for the 2-entry cache: grants one request at a time,
// drives the cache read/write strobes and returns a one-cycle response to the granted client.
module cache_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 7
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic              resp0_hit,
    output logic              resp0_err,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic              resp1_hit,
    output logic              resp1_err,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_val,
    output logic              cache_read,
    output logic              cache_write,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_out_val
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP
    } state_e;

    state_e            state_q;
    logic              gnt_q;
    logic              prio_q;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic              err_q;
    logic              first_q;
    logic              hit_first_q;
    logic [3:0]        cnt_q;

    logic              any_req;
    logic              pick;
    logic              pick_write;
    logic [3:0]        cnt_inc;
    logic              busy;
    logic              in_resp;

    assign any_req    = req0_valid | req1_valid;
    // Contention goes to prio_q; a lone requester wins outright.
    assign pick       = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign pick_write = pick ? req1_write : req0_write;
    assign cnt_inc    = cnt_q + 4'd1;

    // NOTE: all state, including the datapath captures, is reset so every output is 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            prio_q      <= 1'b0;
            ready_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            hit_first_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q   <= pick;
                        prio_q  <= ~pick;
                        ready_q <= 1'b1;
                        addr_q  <= pick ? req1_addr  : req0_addr;
                        wdata_q <= pick ? req1_wdata : req0_wdata;
                        rdata_q <= '0;
                        hit_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= pick_write ? WR_ISSUE : RD_ISSUE;
                    end
                end
                RD_ISSUE: state_q <= RD_WAIT;
                RD_WAIT: begin
                    hit_q   <= cache_hit;
                    rdata_q <= cache_hit ? cache_out_val : '0;
                    state_q <= RESP;
                end
                WR_ISSUE: begin
                    cnt_q   <= '0;
                    first_q <= 1'b0;
                    state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (!first_q) begin
                        first_q     <= 1'b1;
                        hit_first_q <= cache_hit;
                    end
                    // A hit in the very first wait cycle means the line was already present.
                    if (cache_hit) begin
                        hit_q   <= first_q ? hit_first_q : 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == 4'(TIMEOUT)) begin
                            err_q   <= 1'b1;
                            hit_q   <= 1'b0;
                            state_q <= RESP;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign in_resp     = (state_q == RESP);

    assign cache_addr  = busy ? addr_q  : '0;
    assign cache_val   = busy ? wdata_q : '0;
    assign cache_read  = (state_q == RD_ISSUE);
    assign cache_write = (state_q == WR_ISSUE) || (state_q == WR_WAIT);

    assign req0_ready  = ready_q & ~gnt_q;
    assign req1_ready  = ready_q &  gnt_q;

    assign resp0_valid = in_resp & ~gnt_q;
    assign resp0_hit   = resp0_valid & hit_q;
    assign resp0_err   = resp0_valid & err_q;
    assign resp0_rdata = resp0_valid ? rdata_q : '0;

    assign resp1_valid = in_resp & gnt_q;
    assign resp1_hit   = resp1_valid & hit_q;
    assign resp1_err   = resp1_valid & err_q;
    assign resp1_rdata = resp1_valid ? rdata_q : '0;

endmodule
